// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: packs each ADC result into a fixed UART frame and paces a single-byte transmitter.
// Latency: a sample seen in IDLE gives Byte_En on the next cycle. Each later byte follows its Tx_Done by one cycle.
// Backpressure: only one frame is in flight at a time. One sample can be held pending, and a newer sample overwrites it and sets Overrun.
//
// Ports:
//   Clk, Rst_n          clock; synchronous active-low reset
//   m_wr/m_addr/m_wrdata host register writes (ADDR_EN_TX bit0 = enable, ADDR_BAUD bits[2:0] = baud)
//   ADC_Flag/ADC_Data   sample strobe and data
//   Tx_Done             transmitter finished current byte
//   Byte_En/Tx_Data     start strobe and byte to send (held until Tx_Done)
//   Baud_Set            baud select, updated only at frame start
//   Busy, Overrun       frame in flight; sticky pending-overwrite flag
// Optional feature: define UART_FRAME_CHECKSUM_EN to append an 8-bit sum byte (4-byte frame).
module uart_frame_scheduler #(
  parameter logic [7:0] HEADER     = 8'hAA,
  parameter logic [7:0] ADDR_EN_TX = 8'd4,
  parameter logic [7:0] ADDR_BAUD  = 8'd5
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        m_wr,
  input  logic [7:0]  m_addr,
  input  logic [15:0] m_wrdata,
  input  logic        ADC_Flag,
  input  logic [15:0] ADC_Data,
  input  logic        Tx_Done,
  output logic        Byte_En,
  output logic [7:0]  Tx_Data,
  output logic [2:0]  Baud_Set,
  output logic        Busy,
  output logic        Overrun
);

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int NBYTES = 4;
`else
  localparam int NBYTES = 3;
`endif
  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t      state;
  logic        en_tx;
  logic [2:0]  baud_reg;
  logic [15:0] frame_dat;
  logic [1:0]  idx;
  logic        pend_vld;
  logic [15:0] pend_dat;

  // Only the low bits of the write data are meaningful for these registers.
  logic unused_wrdata;
  assign unused_wrdata = &{1'b0, m_wrdata[15:3]};

  // Byte i of the frame built from sample d.
  function automatic logic [7:0] frame_byte(input logic [15:0] d, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = HEADER;
      2'd1:    b = d[15:8];
      2'd2:    b = d[7:0];
`ifdef UART_FRAME_CHECKSUM_EN
      default: b = HEADER + d[15:8] + d[7:0];
`else
      default: b = 8'h00;
`endif
    endcase
    return b;
  endfunction

  wire wr_en_tx = m_wr && (m_addr == ADDR_EN_TX);
  wire wr_baud  = m_wr && (m_addr == ADDR_BAUD);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= IDLE;
      en_tx     <= 1'b1;
      baud_reg  <= 3'd0;
      frame_dat <= 16'd0;
      idx       <= 2'd0;
      pend_vld  <= 1'b0;
      pend_dat  <= 16'd0;
      Byte_En   <= 1'b0;
      Tx_Data   <= 8'd0;
      Baud_Set  <= 3'd0;
      Busy      <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      Byte_En <= 1'b0;

      if (wr_en_tx) en_tx    <= m_wrdata[0];
      if (wr_baud)  baud_reg <= m_wrdata[2:0];

      // While disabled, the pending slot is flushed and new samples are dropped.
      // In IDLE with enable set, a sample goes straight into the frame, not the slot.
      if (!en_tx) begin
        pend_vld <= 1'b0;
      end else if (ADC_Flag && (state != IDLE)) begin
        pend_dat <= ADC_Data;
        pend_vld <= 1'b1;
        if (pend_vld) Overrun <= 1'b1;
      end

      // An enable write clears Overrun. It wins over a same-cycle overwrite.
      if (wr_en_tx) Overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (en_tx && (ADC_Flag || pend_vld)) begin
            // A fresh sample has priority, and an older pending sample stays queued.
            frame_dat <= ADC_Flag ? ADC_Data : pend_dat;
            if (!ADC_Flag) pend_vld <= 1'b0;
            Baud_Set  <= baud_reg;
            idx       <= 2'd0;
            Byte_En   <= 1'b1;
            Tx_Data   <= HEADER;
            Busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          state <= WAIT;
        end
        WAIT: begin
          if (Tx_Done) begin
            if (idx == LAST_IDX) begin
              Busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx     <= idx + 2'd1;
              Byte_En <= 1'b1;
              Tx_Data <= frame_byte(frame_dat, idx + 2'd1);
              state   <= SEND;
            end
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Bench for uart_frame_scheduler: directed stimulus, with a scoreboard of expected bytes checked by a Byte_En monitor.
module tb_uart_frame_scheduler;

  localparam logic [7:0] HDR = 8'hAA;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        m_wr = 1'b0;
  logic [7:0]  m_addr = 8'd0;
  logic [15:0] m_wrdata = 16'd0;
  logic        ADC_Flag = 1'b0;
  logic [15:0] ADC_Data = 16'd0;
  logic        Tx_Done = 1'b0;
  logic        Byte_En;
  logic [7:0]  Tx_Data;
  logic [2:0]  Baud_Set;
  logic        Busy;
  logic        Overrun;

  uart_frame_scheduler dut (
    .Clk(Clk), .Rst_n(Rst_n), .m_wr(m_wr), .m_addr(m_addr), .m_wrdata(m_wrdata),
    .ADC_Flag(ADC_Flag), .ADC_Data(ADC_Data), .Tx_Done(Tx_Done),
    .Byte_En(Byte_En), .Tx_Data(Tx_Data), .Baud_Set(Baud_Set), .Busy(Busy), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] dat;
    logic [2:0] baud;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   be_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every Byte_En pulse must match the next expected byte and baud.
  always @(negedge Clk) begin
    if (Byte_En) begin
      exp_t e;
      be_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_byte: got Tx_Data %0h, expected no Byte_En (t=%0t)", Tx_Data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("tx_byte", {24'd0, Tx_Data}, {24'd0, e.dat});
        chk("tx_baud", {29'd0, Baud_Set}, {29'd0, e.baud});
      end
    end
  end

  task automatic push_frame(input logic [15:0] d, input logic [2:0] b);
    logic [7:0] cks;
    cks = HDR + d[15:8] + d[7:0];
    exp_q.push_back('{HDR, b});
    exp_q.push_back('{d[15:8], b});
    exp_q.push_back('{d[7:0], b});
    if (NB == 4) exp_q.push_back('{cks, b});
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_flag(input logic [15:0] d);
    ADC_Flag = 1'b1;
    ADC_Data = d;
    step;
    ADC_Flag = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    m_wr = 1'b1;
    m_addr = a;
    m_wrdata = d;
    step;
    m_wr = 1'b0;
  endtask

  task automatic do_done(input bit fl, input logic [15:0] d);
    Tx_Done = 1'b1;
    if (fl) begin
      ADC_Flag = 1'b1;
      ADC_Data = d;
    end
    step;
    Tx_Done = 1'b0;
    ADC_Flag = 1'b0;
  endtask

  // The caller is in the SEND or WAIT cycle of byte 'from'. Acknowledge the remaining bytes.
  // If fl is set, a new sample arrives together with the final Tx_Done.
  task automatic finish_frame(input int from, input bit fl, input logic [15:0] fd);
    for (int i = from; i < NB; i++) begin
      step;
      chk("be_one_cycle", {31'd0, Byte_En}, 32'd0);
      do_done(fl && (i == NB - 1), fd);
      if (i < NB - 1) chk("be_after_done", {31'd0, Byte_En}, 32'd1);
      else            chk("busy_end", {31'd0, Busy}, 32'd0);
    end
  endtask

  int snap;

  initial begin
    // Reset
    repeat (2) step;
    Rst_n = 1'b1;
    chk("rst_byte_en", {31'd0, Byte_En}, 32'd0);
    chk("rst_tx_data", {24'd0, Tx_Data}, 32'd0);
    chk("rst_baud", {29'd0, Baud_Set}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_overrun", {31'd0, Overrun}, 32'd0);

    // Basic frame 1234, with a baud write during the frame
    push_frame(16'h1234, 3'd0);
    pulse_flag(16'h1234);
    chk("be_first", {31'd0, Byte_En}, 32'd1);
    chk("busy_high", {31'd0, Busy}, 32'd1);
    step;
    wr(8'd5, 16'd3);
    chk("baud_hold", {29'd0, Baud_Set}, 32'd0);
    finish_frame(0, 1'b0, 16'd0);

    // New baud at the next frame, and two samples during the frame cause an overrun
    push_frame(16'hA5C3, 3'd3);
    push_frame(16'h0002, 3'd3);
    pulse_flag(16'hA5C3);
    chk("baud_new", {29'd0, Baud_Set}, 32'd3);
    step;
    pulse_flag(16'h0001);
    chk("no_overrun_yet", {31'd0, Overrun}, 32'd0);
    pulse_flag(16'h0002);
    chk("overrun_set", {31'd0, Overrun}, 32'd1);
    finish_frame(0, 1'b0, 16'd0);
    step;
    chk("pend_start", {31'd0, Byte_En}, 32'd1);
    finish_frame(0, 1'b0, 16'd0);
    chk("overrun_sticky", {31'd0, Overrun}, 32'd1);
    wr(8'd4, 16'd1);
    chk("overrun_clr", {31'd0, Overrun}, 32'd0);

    // Disable during the frame while a sample is pending
    push_frame(16'h0F0F, 3'd3);
    pulse_flag(16'h0F0F);
    step;
    pulse_flag(16'h7777);
    wr(8'd4, 16'd0);
    finish_frame(0, 1'b0, 16'd0);
    snap = be_cnt;
    repeat (8) step;
    chk("dis_no_byte", be_cnt - snap, 32'd0);
    pulse_flag(16'h1111);
    repeat (3) step;
    chk("dis_busy", {31'd0, Busy}, 32'd0);
    chk("dis_overrun", {31'd0, Overrun}, 32'd0);
    wr(8'd4, 16'd1);
    repeat (4) step;
    chk("pend_dropped", be_cnt - snap, 32'd0);
    chk("pend_dropped_busy", {31'd0, Busy}, 32'd0);

    // A sample that arrives with the final Tx_Done
    push_frame(16'h4242, 3'd3);
    push_frame(16'hFFFF, 3'd3);
    pulse_flag(16'h4242);
    finish_frame(0, 1'b1, 16'hFFFF);
    chk("coinc_gap", {31'd0, Byte_En}, 32'd0);
    step;
    chk("coinc_start", {31'd0, Byte_En}, 32'd1);
    finish_frame(0, 1'b0, 16'd0);

    // Reset during WAIT, with Overrun set and a sample pending
    exp_q.push_back('{HDR, 3'd3});
    pulse_flag(16'h3C3C);
    step;
    pulse_flag(16'h0001);
    pulse_flag(16'h0002);
    chk("pre_rst_overrun", {31'd0, Overrun}, 32'd1);
    Rst_n = 1'b0;
    step;
    Rst_n = 1'b1;
    chk("mrst_byte_en", {31'd0, Byte_En}, 32'd0);
    chk("mrst_tx_data", {24'd0, Tx_Data}, 32'd0);
    chk("mrst_baud", {29'd0, Baud_Set}, 32'd0);
    chk("mrst_busy", {31'd0, Busy}, 32'd0);
    chk("mrst_overrun", {31'd0, Overrun}, 32'd0);
    snap = be_cnt;
    do_done(1'b0, 16'd0);
    chk("stray_done", {31'd0, Byte_En}, 32'd0);
    repeat (4) step;
    chk("stray_no_byte", be_cnt - snap, 32'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
